// File: rtl/gpu_decode_pkg.sv
// Shared decode definitions: opcodes, control bundle layout, mux encodings.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package gpu_decode_pkg;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_BRNZP     = 4'h1;
    localparam logic [3:0] OP_CMP       = 4'h2;
    localparam logic [3:0] OP_ADD       = 4'h3;
    localparam logic [3:0] OP_SUB       = 4'h4;
    localparam logic [3:0] OP_MUL       = 4'h5;
    localparam logic [3:0] OP_DIV       = 4'h6;
    localparam logic [3:0] OP_LDR       = 4'h7;
    localparam logic [3:0] OP_STR       = 4'h8;
    localparam logic [3:0] OP_CONST     = 4'h9;
    localparam logic [3:0] OP_MOVC      = 4'hA;
    localparam logic [3:0] OP_SSY       = 4'hB;
    localparam logic [3:0] OP_SYNC      = 4'hC;
    localparam logic [3:0] OP_JUMP      = 4'hD;
    localparam logic [3:0] OP_ILLEGAL_E = 4'hE;
    localparam logic [3:0] OP_RET       = 4'hF;

    // Register write-back source select
    localparam logic [1:0] REG_IN_ALU   = 2'b00;
    localparam logic [1:0] REG_IN_MEM   = 2'b01;
    localparam logic [1:0] REG_IN_CONST = 2'b10;
    localparam logic [1:0] REG_IN_MOVC  = 2'b11;

    // ALU arithmetic operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    // 16-bit control word, reg_we in the MSB down to spare in the LSB
    typedef struct packed {
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       nzp_we;
        logic       sync;
        logic       ssy;
        logic [1:0] reg_in_mux;
        logic [1:0] alu_arith_mux;
        logic       alu_out_mux;
        logic       pc_mux;
        logic       jump;
        logic       ret;
        logic       illegal;
        logic       spare;
    } ctrl_t;

    // Opcode to control word; every bit not named for an opcode stays 0
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOP:   ;
            OP_BRNZP: c.pc_mux = 1'b1;
            OP_CMP: begin
                c.alu_out_mux = 1'b1;
                c.nzp_we      = 1'b1;
            end
            OP_ADD: begin
                c.reg_we        = 1'b1;
                c.reg_in_mux    = REG_IN_ALU;
                c.alu_arith_mux = ALU_ADD;
            end
            OP_SUB: begin
                c.reg_we        = 1'b1;
                c.reg_in_mux    = REG_IN_ALU;
                c.alu_arith_mux = ALU_SUB;
            end
            OP_MUL: begin
                c.reg_we        = 1'b1;
                c.reg_in_mux    = REG_IN_ALU;
                c.alu_arith_mux = ALU_MUL;
            end
            OP_DIV: begin
                c.reg_we        = 1'b1;
                c.reg_in_mux    = REG_IN_ALU;
                c.alu_arith_mux = ALU_DIV;
            end
            OP_LDR: begin
                c.reg_we     = 1'b1;
                c.mem_re     = 1'b1;
                c.reg_in_mux = REG_IN_MEM;
            end
            OP_STR:   c.mem_we = 1'b1;
            OP_CONST: begin
                c.reg_we     = 1'b1;
                c.reg_in_mux = REG_IN_CONST;
            end
            OP_MOVC: begin
                c.reg_we     = 1'b1;
                c.reg_in_mux = REG_IN_MOVC;
            end
            OP_SSY:   c.ssy  = 1'b1;
            OP_SYNC:  c.sync = 1'b1;
            OP_JUMP:  c.jump = 1'b1;
            OP_RET:   c.ret  = 1'b1;
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush and occupancy count.
// Latency: write in cycle N is visible at the head in cycle N+1.
// Backpressure: wr_rdy is a flop equal to !full, so a push into a full FIFO waits a cycle even if a pop happens.
module decode_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             rdy_q;
    logic             push;
    logic             pop;

    assign rd_vld    = (cnt != '0);
    assign wr_rdy    = rdy_q;
    assign occupancy = cnt;
    assign rd_dat    = mem[rd_ptr];
    assign push      = wr_vld && rdy_q && !flush;
    assign pop       = rd_vld && rd_rdy && !flush;

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + CNT_W'(1);
            2'b01:   cnt_next = cnt - CNT_W'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Pointers, count and registered ready; flush behaves like a soft reset
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rdy_q  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt   <= cnt_next;
            rdy_q <= (cnt_next != FULL_CNT);
        end
    end

    // Storage needs no reset: the head is only consumed while rd_vld is high
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/decode_stage.sv
// Buffered instruction decoder: decodes at push, queues bundles, presents them downstream.
// Latency: instruction accepted in cycle N appears on out_* in cycle N+1 when the queue was empty.
// Backpressure: in_ready is registered !full; flush drops queued and same-cycle traffic.
module decode_stage
    import gpu_decode_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4+3*REG_ADDR_W-1:0]    in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REG_ADDR_W-1:0]        out_rd,
    output logic [REG_ADDR_W-1:0]        out_rs,
    output logic [REG_ADDR_W-1:0]        out_rt,
    output logic [2*REG_ADDR_W-1:0]      out_imm,
    output logic [2:0]                   out_nzp,
    output ctrl_t                        out_ctrl,
    output logic [$clog2(DEPTH):0]       occupancy
);
    localparam int R       = REG_ADDR_W;
    localparam int INSTR_W = 4 + 3 * R;
    localparam int IMM_W   = 2 * R;

    typedef struct packed {
        logic [R-1:0]     rd;
        logic [R-1:0]     rs;
        logic [R-1:0]     rt;
        logic [IMM_W-1:0] imm;
        logic [2:0]       nzp;
        ctrl_t            ctrl;
    } bundle_t;

    logic [3:0] opcode;
    bundle_t    dec;
    bundle_t    head;

    assign opcode = in_instr[INSTR_W-1 -: 4];

    // Field extraction and control decode of the incoming instruction
    always_comb begin
        dec      = '0;
        dec.rd   = in_instr[INSTR_W-5 -: R];
        dec.rs   = in_instr[2*R-1 -: R];
        dec.rt   = in_instr[R-1:0];
        dec.imm  = in_instr[IMM_W-1:0];
        dec.ctrl = decode_ctrl(opcode);
        case (opcode)
            OP_BRNZP, OP_SSY: dec.nzp = in_instr[INSTR_W-5 -: 3];
            OP_MOVC:          dec.nzp = in_instr[3:1];
            default:          dec.nzp = 3'b000;
        endcase
    end

    decode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(bundle_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_vld    (in_valid),
        .wr_rdy    (in_ready),
        .wr_dat    (dec),
        .rd_vld    (out_valid),
        .rd_rdy    (out_ready),
        .rd_dat    (head),
        .occupancy (occupancy)
    );

    // Outputs read zero while the queue is empty so stale storage never leaks
    always_comb begin
        out_rd   = '0;
        out_rs   = '0;
        out_rt   = '0;
        out_imm  = '0;
        out_nzp  = '0;
        out_ctrl = '0;
        if (out_valid) begin
            out_rd   = head.rd;
            out_rs   = head.rs;
            out_rt   = head.rt;
            out_imm  = head.imm;
            out_nzp  = head.nzp;
            out_ctrl = head.ctrl;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_rd, out_rs, out_rt;
    logic [7:0]  out_imm;
    logic [2:0]  out_nzp;
    logic [15:0] out_ctrl;
    logic [1:0]  occupancy;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [18:0] w_in_instr = '0;
    logic        w_out_valid;
    logic [4:0]  w_out_rd, w_out_rs, w_out_rt;
    logic [9:0]  w_out_imm;
    logic [2:0]  w_out_nzp;
    logic [15:0] w_out_ctrl;
    logic [1:0]  w_occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.REG_ADDR_W(4), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
        .out_nzp(out_nzp), .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    decode_stage #(.REG_ADDR_W(5), .DEPTH(2)) dut_w (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_rd(w_out_rd), .out_rs(w_out_rs), .out_rt(w_out_rt), .out_imm(w_out_imm),
        .out_nzp(w_out_nzp), .out_ctrl(w_out_ctrl), .occupancy(w_occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (out_ctrl !== 16'h0000) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0000", out_ctrl); end
        checks++; if ({out_rd, out_rs, out_rt, out_imm, out_nzp} !== 23'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", {out_rd, out_rs, out_rt, out_imm, out_nzp}); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'h3123;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b exp 1", out_valid); end
        checks++; if ({out_rd, out_rs, out_rt} !== 12'h123) begin errors++; $display("FAIL add_regs got %h exp 123", {out_rd, out_rs, out_rt}); end
        checks++; if (out_imm !== 8'h23) begin errors++; $display("FAIL add_imm got %h exp 23", out_imm); end
        checks++; if (out_ctrl !== 16'h8000) begin errors++; $display("FAIL add_ctrl got %h exp 8000", out_ctrl); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL add_occupancy got %0d exp 1", occupancy); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drained_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 16'h0000) begin errors++; $display("FAIL add_drained_ctrl got %h exp 0000", out_ctrl); end
        checks++; if (out_rd !== 4'h0) begin errors++; $display("FAIL add_drained_rd got %h exp 0", out_rd); end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h1A00;
        step();
        in_instr = 16'h2045;
        step();
        // Full: this push must be refused even though a pop happens next edge
        in_instr = 16'h3456;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL full_occupancy got %0d exp 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        checks++; if (out_ctrl !== 16'h0010) begin errors++; $display("FAIL br_ctrl got %h exp 0010", out_ctrl); end
        checks++; if (out_nzp !== 3'b101) begin errors++; $display("FAIL br_nzp got %b exp 101", out_nzp); end
        out_ready = 1'b1;
        step();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL retry_occupancy got %0d exp 1", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL retry_in_ready got %b exp 1", in_ready); end
        checks++; if (out_ctrl !== 16'h1020) begin errors++; $display("FAIL cmp_ctrl got %h exp 1020", out_ctrl); end
        checks++; if (out_nzp !== 3'b000) begin errors++; $display("FAIL cmp_nzp got %b exp 000", out_nzp); end
        step();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL pushpop_occupancy got %0d exp 1", occupancy); end
        checks++; if ({out_rd, out_rs, out_rt} !== 12'h456) begin errors++; $display("FAIL pushpop_regs got %h exp 456", {out_rd, out_rs, out_rt}); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drain_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_opcodes();
        logic [15:0] exp_ctrl [16];
        logic [2:0]  exp_nzp;
        exp_ctrl = '{16'h0000, 16'h0010, 16'h1020, 16'h8000, 16'h8040, 16'h8080, 16'h80C0, 16'hC100,
                     16'h2000, 16'h8200, 16'h8300, 16'h0400, 16'h0800, 16'h0008, 16'h0002, 16'h0004};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int op = 0; op < 16; op++) begin
            in_instr = {op[3:0], 12'h6B3};
            step();
            // instr[11:9]=011 for BR/SSY, instr[3:1]=001 for MOVC
            exp_nzp = (op == 1 || op == 11) ? 3'b011 : (op == 10) ? 3'b001 : 3'b000;
            checks++; if (out_ctrl !== exp_ctrl[op]) begin errors++; $display("FAIL op%0h_ctrl got %h exp %h", op, out_ctrl, exp_ctrl[op]); end
            checks++; if (out_nzp !== exp_nzp) begin errors++; $display("FAIL op%0h_nzp got %b exp %b", op, out_nzp, exp_nzp); end
            checks++; if ({out_rd, out_imm} !== 12'h6B3) begin errors++; $display("FAIL op%0h_fields got %h exp 6b3", op, {out_rd, out_imm}); end
        end
        in_instr = 16'hE000;
        step();
        checks++; if (out_ctrl !== 16'h0002) begin errors++; $display("FAIL illegal_ctrl got %h exp 0002", out_ctrl); end
        in_instr = 16'hA30B;
        step();
        in_valid = 1'b0;
        checks++; if (out_ctrl[9:8] !== 2'b11) begin errors++; $display("FAIL movc_reg_in got %b exp 11", out_ctrl[9:8]); end
        checks++; if (out_nzp !== 3'b101) begin errors++; $display("FAIL movc_nzp got %b exp 101", out_nzp); end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h3111;
        step();
        in_instr = 16'h3222;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL preflush_occupancy got %0d exp 2", occupancy); end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 16'h3333;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occupancy got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h7abc;
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({out_valid, in_ready, occupancy} !== 4'b0100) begin errors++; $display("FAIL midreset_state got %b exp 0100", {out_valid, in_ready, occupancy}); end
        checks++; if (out_ctrl !== 16'h0000) begin errors++; $display("FAIL midreset_ctrl got %h exp 0000", out_ctrl); end
    endtask

    task automatic test_wide();
        w_in_valid = 1'b1;
        w_in_instr = 19'h49C3C;
        step();
        w_in_valid = 1'b0;
        checks++; if (w_out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid got %b exp 1", w_out_valid); end
        checks++; if (w_out_ctrl !== 16'h8200) begin errors++; $display("FAIL wide_ctrl got %h exp 8200", w_out_ctrl); end
        checks++; if (w_out_rd !== 5'd7) begin errors++; $display("FAIL wide_rd got %0d exp 7", w_out_rd); end
        checks++; if (w_out_imm !== 10'h03C) begin errors++; $display("FAIL wide_imm got %h exp 03c", w_out_imm); end
        step();
        checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wide_drained got %b exp 0", w_out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_fill_drain();
        test_opcodes();
        test_flush();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
